pipelined_ctrl_unit: RTL and testbench
======================================

Name: pipelined_ctrl_unit

Overview:
Next-generation control unit for the 5-stage MIPS-style core. It decodes the ID-stage opcode and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It also tracks each stage's destination register. It generates load-use stalls, multi-cycle MUL hold, and jr redirect/flush. It sits between the IF/ID register and the datapath stage muxes, replacing the purely combinational decoder.

Parameters:
OPC_W, 6, opcode width (instruction bits [31:26])
REG_W, 5, register-number width
ALU_CTRL_W, 4, ALU control width
MUL_LAT, 3, EX cycles a MUL occupies (>=1; 1 = no hold)

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
opcode_ID  in  OPC_W  instruction[31:26] in ID
rs_ID  in  REG_W  instruction rs field
rt_ID  in  REG_W  instruction rt field
rd_ID  in  REG_W  instruction rd field
stall_ID  out  1  hold PC and IF/ID (comb.)
flush_IF  out  1  zero IF/ID next cycle (comb.)
PC_Src  out  1  select jr target (comb.)
ex_hold  out  1  datapath holds EX operands (comb.)
ex_alu_src  out  1  EX: 1 = immediate operand
ex_alu_ctrl  out  ALU_CTRL_W  EX ALU operation
ex_slt  out  1  EX set-less-than instruction
ex_dest  out  REG_W  EX destination register
mem_data_write  out  1  MEM store enable
mem_data_read  out  1  MEM load enable
mem_dest  out  REG_W  MEM destination register
wb_reg_write  out  1  WB register-file write enable
wb_data_src  out  1  WB: 1 = memory data
wb_dest  out  REG_W  WB destination register

Behaviour:
- Interface: one clock `clk`. Reset `reset_n` is synchronous and active-low. While `reset_n`=0, at each clk edge all stage registers clear to 0, including all ex_/mem_/wb_ outputs, the dests and the MUL counter. The combinational outputs stall_ID, flush_IF, PC_Src and ex_hold are forced to 0 while reset_n=0. Reset mid-MUL aborts the hold.
- Decode (opcode -> reg_write, dst_rd, alu_src, alu_ctrl, data_write, data_read, wb_src, slt, is_jr, is_mul, uses_rt):
  - ori 14, lui 15: alu 0010, imm
  - slti 10: alu 0010, imm, slt=1
  - mul 26: alu 0011, rd, uses_rt
  - nor 7: alu 0000, rd, uses_rt
  - add 12: alu 0001, rd, uses_rt
  - lw 35: alu 0001, imm, read, wb_src=1
  - sw 43: alu 0001, imm, write, no reg_write, uses_rt
  - jr 2: is_jr
  - others: all 0 (NOP)
  - ID dest = dst_rd ? rd_ID : rt_ID. Every don't-care field is driven as 0, never x.
- Dest tracking: any bundle with reg_write=0 carries dest 0.
- Load-use hazard: raised when the ID/EX bundle has data_read=1, ex_dest!=0, and either ex_dest==rs_ID or (uses_rt && ex_dest==rt_ID).
  - Effect: stall_ID=1 for 1 cycle. At the edge a bubble (all-zero) enters ID/EX.
- MUL hold: a 2-bit+ counter mul_cnt. When a MUL is latched into ID/EX and MUL_LAT>1, mul_cnt loads MUL_LAT-1.
  - While mul_cnt!=0: ex_hold=1 and stall_ID=1; ID/EX retains its contents, EX/MEM receives a bubble, and mul_cnt decrements.
  - Total: a MUL occupies EX for MUL_LAT cycles and reaches MEM exactly once.
- jr: PC_Src = flush_IF = is_jr & ~stall_ID.
  - A jr stalled by a load-use hazard or MUL hold redirects only on its first unstalled cycle.
  - jr then enters ID/EX as a NOP bundle.
- Priority: reset > MUL hold > load-use > normal advance. A load-use condition during ex_hold is re-evaluated after the hold releases.
- Pipeline advance: EX/MEM <= ID/EX (or bubble), and MEM/WB <= EX/MEM. The MEM and WB stages never stall.
- Latency: ID opcode -> ex_* in 1 cycle, mem_* in 2, wb_* in 3, plus stall cycles.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants OP_ORI=14, OP_LUI=15, OP_SLTI=10, OP_MUL=26, OP_NOR=7, OP_ADD=12, OP_LW=35, OP_SW=43, OP_JR=2
  - ALU codes ALU_NOR=0000, ALU_ADD=0001, ALU_CMP=0010, ALU_MUL=0011
  - packed struct ctrl_bundle_t
- Sub-module ctrl_decoder: purely combinational opcode -> ctrl_bundle_t. Instantiated once in ID.

Test Plan:
- reset_n=0 for 2 cycles with opcode 12 applied -> every output 0. First add after release gives ex_alu_ctrl=0001 1 cycle later and wb_reg_write=1 3 cycles later.
- lw rt=5 followed by add rs=5 -> stall_ID=1 for exactly 1 cycle and ID/EX bubble. add reaches EX one cycle late. With rt=0 instead -> no stall.
- mul rd=8, MUL_LAT=3 -> ex_hold=1 for 2 cycles and stall_ID=1 for 2 cycles. mem_dest=8 appears once. Rerun with MUL_LAT=1 -> no hold.
- jr in ID -> PC_Src=1, flush_IF=1 for 1 cycle. lw rt=4 then jr rs=4 -> stall 1 cycle, then PC_Src=1.
- sw then undefined opcode 63 -> mem_data_write=1 for 1 cycle, and opcode 63 yields an all-zero bundle.
- reset_n pulled low during a MUL hold -> counter cleared, ex_hold=0 after the edge, all stage outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/ALU constants and control bundle types for the pipelined control unit
package ctrl_pkg;

  localparam logic [5:0] OP_ORI  = 6'd14;
  localparam logic [5:0] OP_LUI  = 6'd15;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_MUL  = 6'd26;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_ADD  = 6'd12;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_JR   = 6'd2;

  localparam logic [3:0] ALU_NOR = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_CMP = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;

  typedef struct packed {
    logic       reg_write;
    logic       dst_rd;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       data_write;
    logic       data_read;
    logic       wb_src;
    logic       slt;
    logic       is_jr;
    logic       is_mul;
    logic       uses_rt;
  } ctrl_bundle_t;

  // Only the fields still needed past ID travel down the pipe.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       data_write;
    logic       data_read;
    logic       wb_src;
    logic       slt;
  } ex_bundle_t;

  function automatic ex_bundle_t to_ex(input ctrl_bundle_t c);
    ex_bundle_t e;
    e.reg_write  = c.reg_write;
    e.alu_src    = c.alu_src;
    e.alu_ctrl   = c.alu_ctrl;
    e.data_write = c.data_write;
    e.data_read  = c.data_read;
    e.wb_src     = c.wb_src;
    e.slt        = c.slt;
    return e;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode to control bundle decode for the ID stage
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_bundle_t     ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_CMP;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_CMP;
        ctrl.slt       = 1'b1;
      end
      OP_MUL: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_rd    = 1'b1;
        ctrl.alu_ctrl  = ALU_MUL;
        ctrl.is_mul    = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_NOR: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_rd    = 1'b1;
        ctrl.alu_ctrl  = ALU_NOR;
        ctrl.uses_rt   = 1'b1;
      end
      OP_ADD: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_rd    = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.uses_rt   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.data_read = 1'b1;
        ctrl.wb_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.data_write = 1'b1;
        ctrl.uses_rt    = 1'b1;
      end
      OP_JR: begin
        ctrl.is_jr = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// rtl/pipelined_ctrl_unit.sv - registered ID/EX, EX/MEM, MEM/WB control with load-use, MUL hold and jr redirect
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W      = 6,
  parameter int REG_W      = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [OPC_W-1:0]      opcode_ID,
  input  logic [REG_W-1:0]      rs_ID,
  input  logic [REG_W-1:0]      rt_ID,
  input  logic [REG_W-1:0]      rd_ID,
  output logic                  stall_ID,
  output logic                  flush_IF,
  output logic                  PC_Src,
  output logic                  ex_hold,
  output logic                  ex_alu_src,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_slt,
  output logic [REG_W-1:0]      ex_dest,
  output logic                  mem_data_write,
  output logic                  mem_data_read,
  output logic [REG_W-1:0]      mem_dest,
  output logic                  wb_reg_write,
  output logic                  wb_data_src,
  output logic [REG_W-1:0]      wb_dest
);

  localparam int CNT_W = ($clog2(MUL_LAT) < 2) ? 2 : $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  ctrl_bundle_t     id_ctrl;
  logic [REG_W-1:0] id_dest;
  ex_bundle_t       id_ex;
  logic [REG_W-1:0] id_ex_dest;
  logic             mem_reg_write;
  logic             mem_wb_src;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_busy;
  logic             load_use;

  ctrl_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode (opcode_ID),
    .ctrl   (id_ctrl)
  );

  assign id_dest = !id_ctrl.reg_write ? '0 : (id_ctrl.dst_rd ? rd_ID : rt_ID);

  assign mul_busy = (mul_cnt != '0);
  assign load_use = id_ex.data_read && (id_ex_dest != '0) &&
                    ((id_ex_dest == rs_ID) || (id_ctrl.uses_rt && (id_ex_dest == rt_ID)));

  always_comb begin
    stall_ID = 1'b0;
    ex_hold  = 1'b0;
    PC_Src   = 1'b0;
    if (reset_n) begin
      ex_hold  = mul_busy;
      stall_ID = mul_busy || load_use;
      PC_Src   = id_ctrl.is_jr && !(mul_busy || load_use);
    end
  end

  assign flush_IF    = PC_Src;
  assign ex_alu_src  = id_ex.alu_src;
  assign ex_alu_ctrl = ALU_CTRL_W'(id_ex.alu_ctrl);
  assign ex_slt      = id_ex.slt;
  assign ex_dest     = id_ex_dest;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_ex          <= '0;
      id_ex_dest     <= '0;
      mem_data_write <= 1'b0;
      mem_data_read  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_wb_src     <= 1'b0;
      mem_dest       <= '0;
      wb_reg_write   <= 1'b0;
      wb_data_src    <= 1'b0;
      wb_dest        <= '0;
      mul_cnt        <= '0;
    end else begin
      wb_reg_write <= mem_reg_write;
      wb_data_src  <= mem_wb_src;
      wb_dest      <= mem_dest;
      if (mul_busy) begin
        // MUL still occupies EX: keep ID/EX, send a bubble to MEM.
        mem_data_write <= 1'b0;
        mem_data_read  <= 1'b0;
        mem_reg_write  <= 1'b0;
        mem_wb_src     <= 1'b0;
        mem_dest       <= '0;
        mul_cnt        <= mul_cnt - CNT_W'(1);
      end else begin
        mem_data_write <= id_ex.data_write;
        mem_data_read  <= id_ex.data_read;
        mem_reg_write  <= id_ex.reg_write;
        mem_wb_src     <= id_ex.wb_src;
        mem_dest       <= id_ex_dest;
        if (load_use) begin
          id_ex      <= '0;
          id_ex_dest <= '0;
          mul_cnt    <= '0;
        end else begin
          // jr decodes to an otherwise empty bundle, so it enters EX as a NOP.
          id_ex      <= to_ex(id_ctrl);
          id_ex_dest <= id_dest;
          mul_cnt    <= (id_ctrl.is_mul && (MUL_LAT > 1)) ? MUL_LOAD : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// tb/tb_pipelined_ctrl_unit.sv - randomized self-checking bench against an instruction-level reference model
module tb_pipelined_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [5:0] opcode  = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;

  logic       stall_o [2];
  logic       flush_o [2];
  logic       pcsrc_o [2];
  logic       hold_o  [2];
  logic       alu_src_o [2];
  logic [3:0] alu_o   [2];
  logic       slt_o   [2];
  logic [4:0] exd_o   [2];
  logic       mw_o    [2];
  logic       mr_o    [2];
  logic [4:0] memd_o  [2];
  logic       wbrw_o  [2];
  logic       wbsrc_o [2];
  logic [4:0] wbd_o   [2];

  pipelined_ctrl_unit #(.MUL_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset_n(reset_n), .opcode_ID(opcode), .rs_ID(rs), .rt_ID(rt), .rd_ID(rd),
    .stall_ID(stall_o[0]), .flush_IF(flush_o[0]), .PC_Src(pcsrc_o[0]), .ex_hold(hold_o[0]),
    .ex_alu_src(alu_src_o[0]), .ex_alu_ctrl(alu_o[0]), .ex_slt(slt_o[0]), .ex_dest(exd_o[0]),
    .mem_data_write(mw_o[0]), .mem_data_read(mr_o[0]), .mem_dest(memd_o[0]),
    .wb_reg_write(wbrw_o[0]), .wb_data_src(wbsrc_o[0]), .wb_dest(wbd_o[0])
  );

  pipelined_ctrl_unit #(.MUL_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n), .opcode_ID(opcode), .rs_ID(rs), .rt_ID(rt), .rd_ID(rd),
    .stall_ID(stall_o[1]), .flush_IF(flush_o[1]), .PC_Src(pcsrc_o[1]), .ex_hold(hold_o[1]),
    .ex_alu_src(alu_src_o[1]), .ex_alu_ctrl(alu_o[1]), .ex_slt(slt_o[1]), .ex_dest(exd_o[1]),
    .mem_data_write(mw_o[1]), .mem_data_read(mr_o[1]), .mem_dest(memd_o[1]),
    .wb_reg_write(wbrw_o[1]), .wb_data_src(wbsrc_o[1]), .wb_dest(wbd_o[1])
  );

  typedef struct packed {
    bit       rw;
    bit       dst_rd;
    bit       imm;
    bit       wr;
    bit       rd;
    bit       wbsrc;
    bit       slt;
    bit       jr;
    bit       mul;
    bit       uses_rt;
    bit [3:0] alu;
  } dec_t;

  function automatic dec_t spec_dec(input int op);
    dec_t d;
    d = '0;
    case (op)
      14, 15: begin d.rw = 1; d.imm = 1; d.alu = 4'b0010; end
      10:     begin d.rw = 1; d.imm = 1; d.alu = 4'b0010; d.slt = 1; end
      26:     begin d.rw = 1; d.dst_rd = 1; d.alu = 4'b0011; d.mul = 1; d.uses_rt = 1; end
      7:      begin d.rw = 1; d.dst_rd = 1; d.alu = 4'b0000; d.uses_rt = 1; end
      12:     begin d.rw = 1; d.dst_rd = 1; d.alu = 4'b0001; d.uses_rt = 1; end
      35:     begin d.rw = 1; d.imm = 1; d.alu = 4'b0001; d.rd = 1; d.wbsrc = 1; end
      43:     begin d.imm = 1; d.alu = 4'b0001; d.wr = 1; d.uses_rt = 1; end
      2:      begin d.jr = 1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  int lat [2];
  int m_ex_op [2], m_ex_dst [2], m_mem_op [2], m_mem_dst [2], m_wb_op [2], m_wb_dst [2], m_hold [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input int op, input int s, input int t, input int d);
    dec_t ide, exd, memd, wbd;
    bit   hold, lu, stall;
    string sfx;
    @(negedge clk);
    reset_n = rn;
    opcode  = 6'(op);
    rs      = 5'(s);
    rt      = 5'(t);
    rd      = 5'(d);
    #1;
    for (int k = 0; k < 2; k++) begin
      sfx   = $sformatf("[lat%0d]", lat[k]);
      ide   = spec_dec(op);
      exd   = spec_dec(m_ex_op[k]);
      memd  = spec_dec(m_mem_op[k]);
      wbd   = spec_dec(m_wb_op[k]);
      hold  = m_hold[k] > 0;
      lu    = exd.rd && (m_ex_dst[k] != 0) &&
              ((m_ex_dst[k] == s) || (ide.uses_rt && (m_ex_dst[k] == t)));
      stall = rn && (hold || lu);
      check({"stall_ID", sfx},       stall_o[k],   stall);
      check({"ex_hold", sfx},        hold_o[k],    rn && hold);
      check({"PC_Src", sfx},         pcsrc_o[k],   rn && ide.jr && !stall);
      check({"flush_IF", sfx},       flush_o[k],   rn && ide.jr && !stall);
      check({"ex_alu_src", sfx},     alu_src_o[k], exd.imm);
      check({"ex_alu_ctrl", sfx},    alu_o[k],     exd.alu);
      check({"ex_slt", sfx},         slt_o[k],     exd.slt);
      check({"ex_dest", sfx},        exd_o[k],     m_ex_dst[k]);
      check({"mem_data_write", sfx}, mw_o[k],      memd.wr);
      check({"mem_data_read", sfx},  mr_o[k],      memd.rd);
      check({"mem_dest", sfx},       memd_o[k],    m_mem_dst[k]);
      check({"wb_reg_write", sfx},   wbrw_o[k],    wbd.rw);
      check({"wb_data_src", sfx},    wbsrc_o[k],   wbd.wbsrc);
      check({"wb_dest", sfx},        wbd_o[k],     m_wb_dst[k]);

      if (!rn) begin
        m_ex_op[k] = 0;  m_ex_dst[k] = 0;
        m_mem_op[k] = 0; m_mem_dst[k] = 0;
        m_wb_op[k] = 0;  m_wb_dst[k] = 0;
        m_hold[k] = 0;
      end else begin
        m_wb_op[k]  = m_mem_op[k];
        m_wb_dst[k] = m_mem_dst[k];
        if (hold) begin
          m_mem_op[k]  = 0;
          m_mem_dst[k] = 0;
          m_hold[k]    = m_hold[k] - 1;
        end else begin
          m_mem_op[k]  = m_ex_op[k];
          m_mem_dst[k] = m_ex_dst[k];
          if (lu) begin
            m_ex_op[k]  = 0;
            m_ex_dst[k] = 0;
            m_hold[k]   = 0;
          end else begin
            m_ex_op[k]  = ide.jr ? 0 : op;
            m_ex_dst[k] = !ide.rw ? 0 : (ide.dst_rd ? d : t);
            m_hold[k]   = ide.mul ? lat[k] - 1 : 0;
          end
        end
      end
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  int ops [11] = '{14, 15, 10, 26, 7, 12, 35, 43, 2, 63, 0};

  initial begin
    lat[0] = 3;
    lat[1] = 1;

    step(0, 12, 1, 2, 3);
    step(0, 12, 1, 2, 3);
    step(1, 12, 1, 2, 3);
    nops(4);

    step(1, 35, 0, 5, 0);
    step(1, 12, 5, 6, 7);
    step(1, 12, 5, 6, 7);
    nops(3);
    step(1, 35, 0, 0, 0);
    step(1, 12, 0, 1, 2);
    nops(3);

    step(1, 26, 1, 2, 8);
    nops(6);

    step(1, 2, 3, 0, 0);
    nops(1);
    step(1, 35, 0, 4, 0);
    step(1, 2, 4, 0, 0);
    step(1, 2, 4, 0, 0);
    nops(3);

    step(1, 43, 1, 2, 0);
    step(1, 63, 1, 2, 3);
    nops(4);

    step(1, 26, 1, 2, 9);
    step(1, 12, 1, 2, 3);
    step(0, 12, 1, 2, 3);
    step(1, 0, 0, 0, 0);
    nops(3);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 39) != 0),
           ops[$urandom_range(0, 10)],
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
